// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_adder
//  Description : Carry-chunked pipelined adder/subtractor with valid/ready
//                handshake. Each stage adds one CW-bit chunk and registers the
//                chunk carry; unconsumed upper operand bits travel alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_CW = WIDTH / STAGES;

    // Whole pipeline moves together: it shifts when the output slot is empty
    // or being drained this cycle, and freezes otherwise.
    logic w_advance;

    assign w_advance = !g_stage[STAGES-1].r_v || out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be consumed when entering stage k; the low
        // CW bits are the chunk handled here.
        localparam int c_IN_W  = WIDTH - k * c_CW;
        localparam int c_SUM_W = (k + 1) * c_CW;

        logic [c_IN_W-1:0]  w_a_in;
        logic [c_IN_W-1:0]  w_b_in;
        logic               w_c_in;
        logic               w_v_in;
        logic [c_CW:0]      w_chunk;
        logic [c_SUM_W-1:0] w_sum_next;

        logic [c_SUM_W-1:0] r_sum;
        logic               r_c;
        logic               r_v;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + 1, so the carry-in is forced high.
            assign w_a_in     = a;
            assign w_b_in     = sub ? ~b : b;
            assign w_c_in     = sub | cin;
            assign w_v_in     = in_valid;
            assign w_sum_next = w_chunk[c_CW-1:0];
        end else begin : g_body
            assign w_a_in     = g_stage[k-1].g_pass.r_a;
            assign w_b_in     = g_stage[k-1].g_pass.r_b;
            assign w_c_in     = g_stage[k-1].r_c;
            assign w_v_in     = g_stage[k-1].r_v;
            assign w_sum_next = {w_chunk[c_CW-1:0], g_stage[k-1].r_sum};
        end

        assign w_chunk = {1'b0, w_a_in[c_CW-1:0]}
                       + {1'b0, w_b_in[c_CW-1:0]}
                       + {{c_CW{1'b0}}, w_c_in};

        // Chunk result, chunk carry and valid bit for this stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_advance) begin
                r_v   <= w_v_in;
                r_c   <= w_chunk[c_CW];
                r_sum <= w_sum_next;
            end
        end

        if (k < STAGES - 1) begin : g_pass
            logic [c_IN_W-c_CW-1:0] r_a;
            logic [c_IN_W-c_CW-1:0] r_b;

            // Delay the not-yet-added upper chunks alongside the partial sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_a_in[c_IN_W-1:c_CW];
                    r_b <= w_b_in[c_IN_W-1:c_CW];
                end
            end
        end else begin : g_tail
            // Signed overflow: operand signs agree but the result sign differs.
            logic w_ovf;
            logic r_ovf;

            assign w_ovf = (w_a_in[c_IN_W-1] == w_b_in[c_IN_W-1])
                        && (w_chunk[c_CW-1] != w_a_in[c_IN_W-1]);

            // Overflow is resolved in the top stage where both MSBs are present.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_ovf <= w_ovf;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_adder
//  Description : Self-checking bench for pipe_adder (directed table, stall,
//                reset and randomized runs at several stage counts).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    localparam int NRAND = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks       = 0;
    int failures     = 0;
    int rnd_finished = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Independent integer model: {ovf, cout, sum}
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic ci, input logic sb);
        int ux, uy, ur, sx, sy, sr;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + int'(ci);
            co = (ur > 65535);
            sr = sx + sy + int'(ci);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, ur[15:0]};
    endfunction

    // ---------------- main DUT (WIDTH=16, STAGES=4) ----------------
    logic        rst;
    logic        m_in_valid, m_in_ready, m_cin, m_sub;
    logic        m_out_valid, m_out_ready, m_cout, m_ovf;
    logic [15:0] m_a, m_b, m_sum;

    pipe_adder #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (m_in_valid),
        .in_ready (m_in_ready),
        .a        (m_a),
        .b        (m_b),
        .cin      (m_cin),
        .sub      (m_sub),
        .out_valid(m_out_valid),
        .out_ready(m_out_ready),
        .sum      (m_sum),
        .cout     (m_cout),
        .ovf      (m_ovf)
    );

    logic [17:0] m_q[$];
    logic [17:0] m_exp;
    logic [17:0] m_prev_out;
    bit          m_acc;
    bit          m_prev_stall;
    int          m_pops;

    // Called right after inputs are driven (at a negedge); evaluates the
    // transfers of the coming posedge, then waits for the next negedge.
    task automatic step();
        logic [17:0] e;
        #1;
        m_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            m_prev_stall = 1'b0;
        end else begin
            if (m_out_valid && !m_out_ready) begin
                check("stall_in_ready", 32'(m_in_ready), 32'd0);
                if (m_prev_stall)
                    check("stall_hold", 32'({m_ovf, m_cout, m_sum}), 32'(m_prev_out));
                m_prev_stall = 1'b1;
                m_prev_out   = {m_ovf, m_cout, m_sum};
            end else begin
                m_prev_stall = 1'b0;
            end
            if (m_out_valid && m_out_ready) begin
                checks++;
                if (m_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out actual=%h required=none", {m_ovf, m_cout, m_sum});
                end else begin
                    e = m_q.pop_front();
                    m_pops++;
                    if ({m_ovf, m_cout, m_sum} !== e) begin
                        failures++;
                        $display("FAIL result actual=%h required=%h", {m_ovf, m_cout, m_sum}, e);
                    end
                end
            end
            if (m_in_valid && m_in_ready) begin
                m_q.push_back(m_exp);
                m_acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        while (m_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check({nm, "_drained"}, 32'(m_q.size()), 32'd0);
    endtask

    task automatic send_timed(input logic [15:0] x, input logic [15:0] y, input logic ci,
                              input logic sb, input logic [17:0] req, input string nm);
        int lat;
        m_a = x; m_b = y; m_cin = ci; m_sub = sb; m_exp = req;
        m_in_valid  = 1'b1;
        m_out_ready = 1'b1;
        step();
        check({nm, "_accept"}, 32'(m_acc), 32'd1);
        m_in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd4);
        step();
        check({nm, "_popped"}, 32'(m_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int idx, cyc, pops0;
        bit [3:0] pat;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
        m_out_ready = 1'b1; m_exp = '0; m_prev_out = '0; m_prev_stall = 1'b0;
        m_acc = 1'b0; m_pops = 0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(m_out_valid), 32'd0);
        check("rst_in_ready", 32'(m_in_ready), 32'd1);
        check("rst_sum", 32'(m_sum), 32'd0);
        check("rst_cout", 32'(m_cout), 32'd0);
        check("rst_ovf", 32'(m_ovf), 32'd0);
        rst = 1'b0;

        // Single transaction latency
        send_timed(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}, "lat");

        // Table vectors back-to-back
        for (int i = 0; i < 12; i++) begin
            m_a = vecs[i].a; m_b = vecs[i].b; m_cin = vecs[i].cin; m_sub = vecs[i].sub;
            m_exp = {vecs[i].ovf, vecs[i].cout, vecs[i].sum};
            m_in_valid = 1'b1;
            m_out_ready = 1'b1;
            step();
            check("table_accept", 32'(m_acc), 32'd1);
        end
        drain("table");

        // 8 back-to-back transactions with out_ready pattern 1,0,0,1
        pat = 4'b1001;
        idx = 0;
        cyc = 0;
        pops0 = m_pops;
        while ((idx < 8 || m_q.size() != 0) && cyc < 200) begin
            m_in_valid = (idx < 8);
            m_a   = 16'(16'h1357 * (idx + 1));
            m_b   = 16'(16'hF00F ^ (idx * 16'h0999));
            m_cin = idx[1];
            m_sub = idx[0];
            m_exp = ref_model(m_a, m_b, m_cin, m_sub);
            m_out_ready = pat[cyc % 4];
            step();
            if (m_acc) idx++;
            cyc++;
        end
        check("b2b_accepted", 32'(idx), 32'd8);
        check("b2b_results", 32'(m_pops - pops0), 32'd8);
        check("b2b_drained", 32'(m_q.size()), 32'd0);

        // Reset with three transactions in flight
        m_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_a = 16'(16'h0101 * (i + 3)); m_b = 16'h0202; m_cin = 1'b0; m_sub = 1'b0;
            m_exp = ref_model(m_a, m_b, m_cin, m_sub);
            m_in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        m_a = 16'hAAAA; m_exp = ref_model(m_a, m_b, m_cin, m_sub);
        step();
        check("mid_rst_out_valid", 32'(m_out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(m_in_ready), 32'd1);
        check("mid_rst_sum", 32'(m_sum), 32'd0);
        rst = 1'b0;
        m_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("no_stale_out", 32'(m_out_valid), 32'd0);
            step();
        end
        send_timed(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, "post_rst");

        wait (rnd_finished == 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- random runs at several stage counts ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;

        logic        rrst, iv, ir, ci, sb, ov, ordy, co, of;
        logic [15:0] ra, rb, s;
        logic [17:0] q[$];

        pipe_adder #(.WIDTH(16), .STAGES(ST)) u_rdut (
            .clk      (clk),
            .rst      (rrst),
            .in_valid (iv),
            .in_ready (ir),
            .a        (ra),
            .b        (rb),
            .cin      (ci),
            .sub      (sb),
            .out_valid(ov),
            .out_ready(ordy),
            .sum      (s),
            .cout     (co),
            .ovf      (of)
        );

        initial begin
            int outs, cyc;
            bit acc;
            string nm;
            logic [17:0] e;
            outs = 0; cyc = 0; acc = 1'b0;
            nm = $sformatf("rand_st%0d", ST);
            rrst = 1'b1; iv = 1'b0; ra = '0; rb = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b0;
            repeat (2) @(negedge clk);
            rrst = 1'b0;
            while (outs < NRAND && cyc < 40000) begin
                // Upstream holds an offered transaction until it is taken
                if (!(iv && !acc)) begin
                    iv = ($urandom_range(0, 3) != 0);
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    ci = 1'($urandom);
                    sb = 1'($urandom);
                end
                ordy = ($urandom_range(0, 3) != 0);
                #1;
                check({nm, "_in_ready"}, 32'(ir), 32'(!ov || ordy));
                if (ov && ordy) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL %s_unexpected actual=%h required=none", nm, {of, co, s});
                    end else begin
                        e = q.pop_front();
                        if ({of, co, s} !== e) begin
                            failures++;
                            $display("FAIL %s_result actual=%h required=%h", nm, {of, co, s}, e);
                        end
                    end
                    outs++;
                end
                acc = iv && ir;
                if (acc) q.push_back(ref_model(ra, rb, ci, sb));
                cyc++;
                @(negedge clk);
            end
            check({nm, "_count"}, 32'(outs), 32'(NRAND));
            rnd_finished++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
